// File: rtl/line_fill_mem.sv
// rtl/line_fill_mem.sv - line-fill backing store with fixed-latency single-outstanding response
//
// Purpose: word-addressed 32-bit backing store that serves one cache-line read
// at a time. A request is granted from IDLE, and the full line comes back
// LATENCY cycles after the grant. A separate write port updates single words
// at any time.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rstn       in   asynchronous active-low reset (the store itself is not cleared)
//   mem_req    in   line request, held by the requester until mem_gnt
//   mem_addr   in   byte address; the low log2(LINE_BYTES) bits are ignored
//   mem_gnt    out  one-cycle request-accepted pulse
//   mem_rvalid out  one-cycle line-valid pulse, LATENCY cycles after mem_gnt
//   mem_rdata  out  full line, word i at [32i+31:32i]; zero unless mem_rvalid
//   mem_err    out  out-of-range flag, coincident with mem_rvalid
//   wr_en      in   word write strobe
//   wr_addr    in   byte address of the write word; bits [1:0] ignored
//   wr_data    in   write data, little-endian bytes 4n..4n+3
//
// Optional feature: define LINE_FILL_MEM_BOUNDS_CHECK_EN to flag reads at or
// above DEPTH_WORDS*4 (zero data, mem_err=1) and drop out-of-range writes.
// Without it, addresses wrap modulo DEPTH_WORDS and mem_err stays 0.
module line_fill_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_BYTES  = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mem_req,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_gnt,
  output logic                    mem_rvalid,
  output logic [LINE_BYTES*8-1:0] mem_rdata,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [31:0]             wr_data,
  output logic                    mem_err
);

  localparam int WORDS_PER_LINE = LINE_BYTES / 4;
  localparam int WIDX_W         = $clog2(DEPTH_WORDS);
  localparam int CNT_W          = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]   line_addr, line_addr_next;
  logic                    gnt_next;
  logic                    rvalid_next;
  logic                    err_next;
  logic [LINE_BYTES*8-1:0] rdata_next;
  logic [LINE_BYTES*8-1:0] line_data;
  logic [WIDX_W-1:0]       line_base;
  logic                    rd_oob;
  logic                    wr_ok;

  logic [31:0] store [DEPTH_WORDS];

`ifdef LINE_FILL_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
  assign rd_oob = ({1'b0, line_addr} >= LIMIT);
  assign wr_ok  = ({1'b0, wr_addr} < LIMIT);
`else
  assign rd_oob = 1'b0;
  assign wr_ok  = 1'b1;
`endif

  // Upper address bits beyond the store are intentionally discarded (wrap).
  logic unused_bits;
  assign unused_bits = &{1'b0, wr_addr, line_addr};

  // The store has no reset so preloaded contents survive rstn; writes are
  // blocked while rstn is low.
  always_ff @(posedge clk) begin
    if (rstn && wr_en && wr_ok) begin
      store[wr_addr[WIDX_W+1:2]] <= wr_data;
    end
  end

  // Line words are contiguous from an aligned base, so base+i never carries
  // out of the line.
  assign line_base = line_addr[WIDX_W+1:2];

  always_comb begin
    line_data = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      line_data[32*i +: 32] = store[line_base + WIDX_W'(i)];
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    line_addr_next = line_addr;
    gnt_next       = 1'b0;
    rvalid_next    = 1'b0;
    err_next       = 1'b0;
    rdata_next     = '0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          line_addr_next = mem_addr & ~LINE_MASK;
          gnt_next       = 1'b1;
          cnt_next       = CNT_W'(LATENCY);
          state_next     = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        // Counter holds 1 at the edge LATENCY edges after the grant edge,
        // which is the edge that must raise mem_rvalid and capture the line.
        if (cnt == CNT_W'(1)) begin
          rvalid_next = 1'b1;
          err_next    = rd_oob;
          rdata_next  = rd_oob ? '0 : line_data;
          state_next  = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      line_addr  <= '0;
      mem_gnt    <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      line_addr  <= line_addr_next;
      mem_gnt    <= gnt_next;
      mem_rvalid <= rvalid_next;
      mem_rdata  <= rdata_next;
      mem_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_line_fill_mem.sv
// tb/tb_line_fill_mem.sv - randomized self-checking bench for line_fill_mem
module tb_line_fill_mem;

  localparam int L     = 4;
  localparam int DEPTH = 1024;

  logic         clk;
  logic         rstn;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         mem_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  line_fill_mem #(
    .ADDR_WIDTH(32), .LINE_BYTES(16), .DEPTH_WORDS(DEPTH), .LATENCY(L)
  ) dut (
    .clk(clk), .rstn(rstn), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_oob(input logic [31:0] a);
`ifdef LINE_FILL_MEM_BOUNDS_CHECK_EN
    return (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] a);
    logic [127:0] r;
    logic [31:0]  base;
    r    = '0;
    base = (a & ~32'hF) >> 2;
    if (!is_oob(a & ~32'hF)) begin
      for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_mem[(base + i) % DEPTH];
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    if (!is_oob(a)) ref_mem[(a >> 2) % DEPTH] = d;
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  // Full request from IDLE; optional write strobed at edge wr_k after the grant edge.
  task automatic line_req(input logic [31:0] a, input int wr_k,
                          input logic [31:0] wa, input logic [31:0] wd);
    int           n;
    logic [127:0] e;
    mem_req = 1'b1; mem_addr = a; n = 0;
    do begin tick(); n++; end while (!mem_gnt && n < 16);
    chk("gnt", mem_gnt, 1);
    chk("gnt_latency", n, 1);
    if (!mem_gnt) begin mem_req = 1'b0; return; end
    for (int k = 1; k <= L; k++) begin
      mem_req  = (k < L) ? 1'($urandom) : 1'b0;
      mem_addr = $urandom;
      if (k == wr_k) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
      tick();
      wr_en = 1'b0;
      chk("gnt_single", mem_gnt, 0);
      if (k < L) begin
        chk("rvalid_early", mem_rvalid, 0);
        chk("rdata_zero", mem_rdata, 0);
      end else begin
        e = exp_line(a);
        chk("rvalid", mem_rvalid, 1);
        chk("rdata", mem_rdata, e);
        chk("err", mem_err, is_oob(a & ~32'hF));
      end
      if (k == wr_k) model_write(wa, wd);
    end
    tick();
    chk("rvalid_drop", mem_rvalid, 0);
    chk("rdata_drop", mem_rdata, 0);
    chk("err_drop", mem_err, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_gnt"}, mem_gnt, 0);
    chk({tag, "_rvalid"}, mem_rvalid, 0);
    chk({tag, "_rdata"}, mem_rdata, 0);
    chk({tag, "_err"}, mem_err, 0);
  endtask

  initial begin
    int g0, g1, ng, nv, cyc;
    int v_at [2];
    logic [31:0] a, wa;

    rstn = 1'b0; mem_req = 1'b0; mem_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) write_word(32'(i * 4), $urandom);

    // Directed preload and request at 0xC.
    write_word(32'h0, 32'h11111111);
    write_word(32'h4, 32'h22222222);
    write_word(32'h8, 32'h33333333);
    write_word(32'hC, 32'h44444444);
    line_req(32'hC, 0, 0, 0);
    chk("preload_line", exp_line(32'hC), 128'h44444444_33333333_22222222_11111111);

    // Write two edges before rvalid is visible; write at the rvalid edge is not.
    line_req(32'h10, L - 2, 32'h14, 32'hA5A5_0001);
    line_req(32'h10, L, 32'h14, 32'h5A5A_0002);
    line_req(32'h10, 0, 0, 0);

    // Requester held high: two grants L+2 apart, one rvalid each.
    mem_req = 1'b1; mem_addr = 32'h10; ng = 0; nv = 0; g0 = -1; g1 = -1;
    v_at[0] = -1; v_at[1] = -1;
    for (cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (mem_gnt) begin
        if (ng == 0) begin g0 = cyc; mem_addr = 32'h20; end
        else begin g1 = cyc; mem_req = 1'b0; end
        ng++;
      end
      if (mem_rvalid) begin
        if (nv < 2) v_at[nv] = cyc;
        chk("b2b_rdata", mem_rdata, exp_line(nv == 0 ? 32'h10 : 32'h20));
        nv++;
      end
    end
    mem_req = 1'b0;
    chk("b2b_grants", ng, 2);
    chk("b2b_spacing", g1 - g0, L + 2);
    chk("b2b_rvalids", nv, 2);
    chk("b2b_rv0", v_at[0] - g0, L);
    chk("b2b_rv1", v_at[1] - g1, L);

    // Reset in WAIT drops the response; store survives and ignores writes under reset.
    mem_req = 1'b1; mem_addr = 32'h0;
    tick();
    chk("rst_gnt", mem_gnt, 1);
    mem_req = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    check_outputs_zero("in_rst");
    rstn = 1'b1;
    nv = 0;
    for (int k = 0; k < L + 3; k++) begin
      tick();
      if (mem_rvalid) nv++;
    end
    chk("rst_no_rvalid", nv, 0);
    line_req(32'h0, 0, 0, 0);
    chk("rst_data_kept", mem_rdata === '0, 1);

    // Beyond the store: error with the bounds check, wrap without.
    line_req(32'h1000, 0, 0, 0);

    // Randomized requests with optional writes landing during the wait.
    for (int r = 0; r < 40; r++) begin
      a  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h3FFF) : ($urandom & 32'hFFF);
      wa = ($urandom_range(0, 1) == 0) ? ((a & ~32'hF) | ($urandom & 32'hC))
                                       : ($urandom & 32'h1FFC);
      line_req(a, int'($urandom_range(0, L)), wa, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
